keypad_hit_encoder: RTL and testbench

Front end for the mole game's keypad input: conditions eight raw push-button lines into clean, one-at-a-time hit events. It synchronises and debounces each key, detects press edges, queues presses in a pending mask and presents them as a one-hot hit with a valid/ack handshake. It sits between the board keypad pins and the game core's one-hot `keypad` input.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/key_debounce.sv | 49 ++++
 rtl/keypad_hit_encoder.sv | 187 ++++++++++++++++++
 tb/tb_keypad_hit_encoder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad hit encoder.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (see keypad_hit_encoder.sv).
package keypad_pkg;

  localparam int unsigned NKEYS  = 8;
  localparam int unsigned KIDX_W = 3;

  typedef enum logic {
    KP_IDLE    = 1'b0,
    KP_PRESENT = 1'b1
  } kp_state_e;

  // Presented hit payload: binary index plus one-hot form of the same key.
  typedef struct packed {
    logic [KIDX_W-1:0] idx;
    logic [NKEYS-1:0]  onehot;
  } kp_hit_t;

  // Lowest set bit of a key mask; all-zero result for an empty mask.
  function automatic kp_hit_t kp_lowest(input logic [NKEYS-1:0] mask);
    kp_hit_t r;
    r = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.idx       = KIDX_W'(i);
        r.onehot    = '0;
        r.onehot[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key conditioner: 2-flop synchroniser, sampled history, debounced level
// and a one-cycle press pulse aligned with the rising debounced level.
module key_debounce #(
  parameter int unsigned DB_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  input  logic tick,
  output logic held,
  output logic press
);

  logic [1:0]          sync;
  logic [DB_DEPTH-1:0] hist;
  logic [DB_DEPTH-1:0] hist_next;

  assign hist_next = {hist[DB_DEPTH-2:0], sync[1]};

  // Bring the asynchronous key line into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], key_raw};
    end
  end

  // Sample on tick; change level only when the whole history agrees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '0;
      held  <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (tick) begin
        hist <= hist_next;
        if (&hist_next) begin
          held  <= 1'b1;
          press <= ~held;
        end else if (~|hist_next) begin
          held <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_hit_encoder.sv
// Keypad front end: debounces eight keys, queues press edges in a pending
// mask and presents them one at a time as a one-hot hit with valid/ack.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN enables per-key auto-repeat
// every REPEAT_TICKS sample ticks while a key stays held.
module keypad_hit_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = 50000,
  parameter int unsigned DB_DEPTH     = 4,
  parameter int unsigned REPEAT_TICKS = 250
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [NKEYS-1:0]  key_raw,
  input  logic              hit_ack,
  output logic              hit_valid,
  output logic [NKEYS-1:0]  hit_onehot,
  output logic [KIDX_W-1:0] hit_idx,
  output logic [NKEYS-1:0]  held,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  // Elaboration-time parameter sanity.
  if (SAMPLE_DIV < 2) begin : g_bad_div
    $error("SAMPLE_DIV must be at least 2");
  end
  if (DB_DEPTH < 2) begin : g_bad_depth
    $error("DB_DEPTH must be at least 2");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat
    $error("REPEAT_TICKS must be at least 1");
  end

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [NKEYS-1:0]  press;
  logic [NKEYS-1:0]  evt;
  logic [NKEYS-1:0]  pending;
  logic [NKEYS-1:0]  clr;
  logic [NKEYS-1:0]  drop;
  logic [3:0]        ndrop;
  logic [8:0]        drop_sum;
  kp_state_e         state;
  kp_state_e         state_next;
  logic              valid_next;
  logic [NKEYS-1:0]  onehot_next;
  logic [KIDX_W-1:0] idx_next;
  kp_hit_t           low;

  assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  // Free-running sample divider.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_debounce #(
      .DB_DEPTH(DB_DEPTH)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (RESET),
      .key_raw(key_raw[k]),
      .tick   (tick),
      .held   (held[k]),
      .press  (press[k])
    );
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_TICKS + 1);

  logic [RPT_W-1:0] rpt_cnt [NKEYS];
  logic [NKEYS-1:0] rpt_pulse;

  // Re-raise a press every REPEAT_TICKS ticks while held; clear on release.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NKEYS; i++) rpt_cnt[i] <= '0;
      rpt_pulse <= '0;
    end else begin
      rpt_pulse <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        if (!held[i]) begin
          rpt_cnt[i] <= '0;
        end else if (tick) begin
          if (rpt_cnt[i] == RPT_W'(REPEAT_TICKS - 1)) begin
            rpt_cnt[i]   <= '0;
            rpt_pulse[i] <= 1'b1;
          end else begin
            rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
          end
        end
      end
    end
  end

  assign evt = press | rpt_pulse;
`else
  assign evt = press;
`endif

  // Presses that find their pending bit still set (and not being consumed).
  assign drop = evt & pending & ~clr;

  // Count drops this cycle and add with saturation.
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NKEYS; i++) begin
      ndrop = ndrop + 4'(drop[i]);
    end
    drop_sum = {1'b0, drop_cnt} + 9'(ndrop);
  end

  // Pending mask (new press wins over same-cycle clear) and drop counter.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= (pending & ~clr) | evt;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // Output FSM next state and next registered outputs.
  always_comb begin
    state_next  = state;
    valid_next  = hit_valid;
    onehot_next = hit_onehot;
    idx_next    = hit_idx;
    clr         = '0;
    low         = kp_lowest(pending);
    case (state)
      KP_IDLE: begin
        if (pending != '0) begin
          state_next  = KP_PRESENT;
          valid_next  = 1'b1;
          onehot_next = low.onehot;
          idx_next    = low.idx;
          clr         = low.onehot;
        end
      end
      KP_PRESENT: begin
        if (hit_ack) begin
          if (pending != '0) begin
            onehot_next = low.onehot;
            idx_next    = low.idx;
            clr         = low.onehot;
          end else begin
            state_next  = KP_IDLE;
            valid_next  = 1'b0;
            onehot_next = '0;
            idx_next    = '0;
          end
        end
      end
      default: begin
        state_next = KP_IDLE;
      end
    endcase
  end

  // FSM state and registered hit outputs.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state      <= KP_IDLE;
      hit_valid  <= 1'b0;
      hit_onehot <= '0;
      hit_idx    <= '0;
    end else begin
      state      <= state_next;
      hit_valid  <= valid_next;
      hit_onehot <= onehot_next;
      hit_idx    <= idx_next;
    end
  end

endmodule

// File: tb/tb_keypad_hit_encoder.sv
// Self-checking bench for keypad_hit_encoder (SAMPLE_DIV=4, DB_DEPTH=4,
// REPEAT_TICKS=3): table of press patterns plus directed corner sequences.
module tb_keypad_hit_encoder;

  logic       clk;
  logic       RESET;
  logic [7:0] key_raw;
  logic       hit_ack;
  logic       hit_valid;
  logic [7:0] hit_onehot;
  logic [2:0] hit_idx;
  logic [7:0] held;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  keypad_hit_encoder #(
    .SAMPLE_DIV  (4),
    .DB_DEPTH    (4),
    .REPEAT_TICKS(3)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .key_raw   (key_raw),
    .hit_ack   (hit_ack),
    .hit_valid (hit_valid),
    .hit_onehot(hit_onehot),
    .hit_idx   (hit_idx),
    .held      (held),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] keys;
    int         exp_hits;
    logic [2:0] exp_first_idx;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lo);
    checks++;
    if (act < lo) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, lo);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] lowbit(input logic [7:0] m);
    return m & (~m + 8'd1);
  endfunction

  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // Press a key pattern for hi cycles then release it for lo cycles.
  task automatic pulse_keys(input logic [7:0] k, input int hi, input int lo);
    key_raw = k;
    cyc(hi);
    key_raw = 8'h00;
    cyc(lo);
  endtask

  vec_t tab [5];

  initial begin
    int         nh;
    int         wait_n;
    logic [7:0] model;
    logic [7:0] exp_oh;
    logic [2:0] first_idx;
    logic       stable;

    tab[0] = '{keys: 8'h01, exp_hits: 1, exp_first_idx: 3'd0};
    tab[1] = '{keys: 8'h80, exp_hits: 1, exp_first_idx: 3'd7};
    tab[2] = '{keys: 8'h0F, exp_hits: 4, exp_first_idx: 3'd0};
    tab[3] = '{keys: 8'h50, exp_hits: 2, exp_first_idx: 3'd4};
    tab[4] = '{keys: 8'hFF, exp_hits: 8, exp_first_idx: 3'd0};

    // Reset state with random key activity.
    RESET   = 1'b0;
    hit_ack = 1'b1;
    key_raw = 8'($urandom);
    cyc(3);
    key_raw = 8'($urandom);
    cyc(2);
    check("rst hit_valid", 32'(hit_valid), 0);
    check("rst hit_onehot", 32'(hit_onehot), 0);
    check("rst hit_idx", 32'(hit_idx), 0);
    check("rst held", 32'(held), 0);
    check("rst drop_cnt", 32'(drop_cnt), 0);
    key_raw = 8'h00;
    RESET   = 1'b1;
    nh = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hit_valid) nh++;
    end
    check("idle no hits", 32'(nh), 0);

    // Table of press patterns with ack held high.
    for (int v = 0; v < 5; v++) begin
      key_raw   = tab[v].keys;
      hit_ack   = 1'b1;
      model     = tab[v].keys;
      nh        = 0;
      first_idx = 3'd0;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        if (hit_valid) begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if (model == 8'h00) model = tab[v].keys;
`endif
          exp_oh = lowbit(model);
          check("vec hit_onehot", 32'(hit_onehot), 32'(exp_oh));
          check("vec hit_idx", 32'(hit_idx), 32'(oh2idx(exp_oh)));
          if (nh == 0) first_idx = hit_idx;
          model = model & ~exp_oh;
          nh++;
        end
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      check_ge("vec hit count", nh, tab[v].exp_hits);
`else
      check("vec hit count", 32'(nh), 32'(tab[v].exp_hits));
`endif
      check("vec first idx", 32'(first_idx), 32'(tab[v].exp_first_idx));
      check("vec held", 32'(held), 32'(tab[v].keys));
      key_raw = 8'h00;
      nh = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (hit_valid && c > 4) nh++;
      end
      check("vec release no event", 32'(nh), 0);
      check("vec held cleared", 32'(held), 0);
    end

    // Bounce rejection on key 2.
    hit_ack = 1'b1;
    key_raw = 8'h00;
    nh = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) key_raw[2] = ~key_raw[2];
      @(negedge clk);
      if (hit_valid) nh++;
    end
    check("bounce no hit", 32'(nh), 0);
    check("bounce held low", 32'(held[2]), 0);
    key_raw[2] = 1'b1;
    cyc(3);
    check("bounce held early", 32'(held[2]), 0);
    nh = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (hit_valid) begin
        nh++;
        check("bounce onehot", 32'(hit_onehot), 32'h04);
        check("bounce idx", 32'(hit_idx), 2);
      end
    end
    check("bounce held", 32'(held[2]), 1);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("bounce one hit", 32'(nh), 1);
`endif
    key_raw = 8'h00;
    cyc(40);

    // Simultaneous press of keys 5 and 1 with ack tied high.
    key_raw = 8'h22;
    wait_n  = 0;
    while (!hit_valid && wait_n < 80) begin
      @(negedge clk);
      wait_n++;
    end
    check("simul first valid", 32'(hit_valid), 1);
    check("simul first onehot", 32'(hit_onehot), 32'h02);
    check("simul first idx", 32'(hit_idx), 1);
    @(negedge clk);
    check("simul second valid", 32'(hit_valid), 1);
    check("simul second onehot", 32'(hit_onehot), 32'h20);
    check("simul second idx", 32'(hit_idx), 5);
    @(negedge clk);
    check("simul done valid", 32'(hit_valid), 0);
    check("simul done onehot", 32'(hit_onehot), 0);
    key_raw = 8'h00;
    cyc(40);

    // Backpressure and drop: key 0 held presented, key 3 pressed twice.
    hit_ack = 1'b0;
    pulse_keys(8'h01, 30, 30);
    check("bp valid", 32'(hit_valid), 1);
    check("bp onehot", 32'(hit_onehot), 32'h01);
    stable = 1'b1;
    for (int p = 0; p < 2; p++) begin
      key_raw = 8'h08;
      for (int c = 0; c < 60; c++) begin
        if (c == 30) key_raw = 8'h00;
        @(negedge clk);
        if (!hit_valid || hit_onehot != 8'h01 || hit_idx != 3'd0) stable = 1'b0;
      end
    end
    check("bp stable", 32'(stable), 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    check_ge("bp drop_cnt", int'(drop_cnt), 1);
`else
    check("bp drop_cnt", 32'(drop_cnt), 1);
`endif
    hit_ack = 1'b1;
    @(negedge clk);
    check("bp next valid", 32'(hit_valid), 1);
    check("bp next onehot", 32'(hit_onehot), 32'h08);
    check("bp next idx", 32'(hit_idx), 3);
    @(negedge clk);
    check("bp drained", 32'(hit_valid), 0);
    cyc(20);

    // Reset mid-operation discards presented and pending hits.
    hit_ack = 1'b0;
    pulse_keys(8'h40, 30, 0);
    check("mid valid before rst", 32'(hit_valid), 1);
    check("mid onehot before rst", 32'(hit_onehot), 32'h40);
    RESET = 1'b0;
    #1;
    check("mid async valid", 32'(hit_valid), 0);
    check("mid async onehot", 32'(hit_onehot), 0);
    key_raw = 8'h00;
    cyc(3);
    RESET = 1'b1;
    nh = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hit_valid) nh++;
    end
    check("mid no stale hit", 32'(nh), 0);
    check("mid drop_cnt", 32'(drop_cnt), 0);

    // Drop saturation: key 4 presented, one pending, then 300 drops.
    hit_ack = 1'b0;
    for (int p = 0; p < 100; p++) pulse_keys(8'h10, 20, 20);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("sat drop_cnt mid", 32'(drop_cnt), 98);
`endif
    for (int p = 0; p < 202; p++) pulse_keys(8'h10, 20, 20);
    check("sat drop_cnt", 32'(drop_cnt), 255);
    check("sat onehot", 32'(hit_onehot), 32'h10);
    hit_ack = 1'b1;
    cyc(10);
    check("sat drained", 32'(hit_valid), 0);
    check("sat drop_cnt hold", 32'(drop_cnt), 255);

    // Long hold of key 7 with ack high: repeats only when enabled.
    RESET = 1'b0;
    cyc(2);
    RESET = 1'b1;
    hit_ack = 1'b1;
    key_raw = 8'h80;
    nh = 0;
    for (int c = 0; c < 120; c++) begin
      if (c == 100) key_raw = 8'h00;
      @(negedge clk);
      if (hit_valid) begin
        nh++;
        check("hold onehot", 32'(hit_onehot), 32'h80);
      end
    end
    cyc(30);
`ifdef KEYPAD_AUTOREPEAT_EN
    check_ge("hold repeat hits", nh, 5);
`else
    check("hold single hit", 32'(nh), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
